// File: rtl/exp_normalize_unit_if.sv
// Valid/ready bus for the post-add normalization stage (upstream and downstream sides).
// Defining EXP_NORM_INEXACT_EN adds the o_inexact result flag.
interface exp_normalize_unit_if #(
   parameter int SIZE_EXP  = 8,
   parameter int SIZE_MANT = 23
);
   logic                 i_valid;
   logic                 o_ready;
   logic [SIZE_EXP-1:0]  i_exp_greater;
   logic [SIZE_MANT+1:0] i_mant;
   logic                 o_valid;
   logic                 i_ready;
   logic [SIZE_EXP-1:0]  o_exp;
   logic [SIZE_MANT-1:0] o_mant;
   logic                 o_zero;
   logic                 o_overflow;
   logic                 o_underflow;
`ifdef EXP_NORM_INEXACT_EN
   logic                 o_inexact;
`endif

   modport slave (
      input  i_valid, i_exp_greater, i_mant, i_ready,
      output o_ready, o_valid, o_exp, o_mant, o_zero, o_overflow, o_underflow
`ifdef EXP_NORM_INEXACT_EN
      , output o_inexact
`endif
   );

   modport master (
      output i_valid, i_exp_greater, i_mant, i_ready,
      input  o_ready, o_valid, o_exp, o_mant, o_zero, o_overflow, o_underflow
`ifdef EXP_NORM_INEXACT_EN
      , input o_inexact
`endif
   );
endinterface

// File: rtl/exp_normalize_unit.sv
// Two-stage FP post-add normalizer: carry right-shift or leading-zero left-shift, exponent fix-up, flags.
// Defining EXP_NORM_INEXACT_EN adds the pipelined o_inexact flag.
module exp_normalize_unit #(
   parameter int SIZE_EXP  = 8,
   parameter int SIZE_MANT = 23
) (
   input logic                 i_clk,
   input logic                 i_rst_n,
   exp_normalize_unit_if.slave bus
);
   localparam int W   = SIZE_MANT + 2;
   localparam int LZW = $clog2(W);
   localparam int EW  = SIZE_EXP + 1;
   localparam logic [EW-1:0] EXP_MAX = {1'b0, {SIZE_EXP{1'b1}}};

   logic                 s2_load;
   logic                 s1_load;
   logic [LZW-1:0]       lzc;

   logic                 s1_valid_q, s1_valid_d;
   logic [SIZE_EXP-1:0]  s1_exp_q, s1_exp_d;
   logic [W-1:0]         s1_mant_q, s1_mant_d;
   logic                 s1_carry_q, s1_carry_d;
   logic [LZW-1:0]       s1_lzc_q, s1_lzc_d;

   logic                 s2_valid_q, s2_valid_d;
   logic [SIZE_EXP-1:0]  s2_exp_q, s2_exp_d;
   logic [SIZE_MANT-1:0] s2_mant_q, s2_mant_d;
   logic                 s2_zero_q, s2_zero_d;
   logic                 s2_ovf_q, s2_ovf_d;
   logic                 s2_unf_q, s2_unf_d;

   logic [EW-1:0]        exp_ext;
   logic [EW-1:0]        exp_inc;
   logic [EW-1:0]        lzc_ext;
   logic [SIZE_EXP-1:0]  res_exp;
   logic [SIZE_MANT-1:0] res_mant;
   logic                 res_zero;
   logic                 res_ovf;
   logic                 res_unf;

   assign s2_load     = !s2_valid_q || bus.i_ready;
   assign s1_load     = !s1_valid_q || s2_load;
   assign bus.o_ready = s1_load;

   // Highest set bit below the carry wins; an all-zero field reports W-1.
   always_comb begin
      lzc = LZW'(W - 1);
      for (int i = 0; i < W - 1; i++) begin
         if (bus.i_mant[i]) lzc = LZW'(W - 2 - i);
      end
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_exp_d   = s1_exp_q;
      s1_mant_d  = s1_mant_q;
      s1_carry_d = s1_carry_q;
      s1_lzc_d   = s1_lzc_q;
      if (s1_load) begin
         s1_valid_d = bus.i_valid;
         if (bus.i_valid) begin
            s1_exp_d   = bus.i_exp_greater;
            s1_mant_d  = bus.i_mant;
            s1_carry_d = bus.i_mant[W-1];
            s1_lzc_d   = lzc;
         end
      end
   end

   // Exponent math is one bit wider so neither the increment nor the compare can wrap.
   always_comb begin
      exp_ext  = {1'b0, s1_exp_q};
      exp_inc  = exp_ext + EW'(1);
      lzc_ext  = EW'(s1_lzc_q);
      res_exp  = '0;
      res_mant = '0;
      res_zero = 1'b0;
      res_ovf  = 1'b0;
      res_unf  = 1'b0;
      if (s1_mant_q == '0) begin
         res_zero = 1'b1;
      end else if (s1_carry_q) begin
         if (exp_inc >= EXP_MAX) begin
            res_ovf = 1'b1;
            res_exp = '1;
         end else begin
            res_exp  = exp_inc[SIZE_EXP-1:0];
            res_mant = s1_mant_q[W-2:1];
         end
      end else if (s1_lzc_q == '0) begin
         res_exp  = s1_exp_q;
         res_mant = s1_mant_q[W-3:0];
      end else if (lzc_ext < exp_ext) begin
         res_exp  = SIZE_EXP'(exp_ext - lzc_ext);
         res_mant = SIZE_MANT'(s1_mant_q << s1_lzc_q);
      end else begin
         res_unf = 1'b1;
      end
   end

   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_exp_d   = s2_exp_q;
      s2_mant_d  = s2_mant_q;
      s2_zero_d  = s2_zero_q;
      s2_ovf_d   = s2_ovf_q;
      s2_unf_d   = s2_unf_q;
      if (s2_load) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_exp_d  = res_exp;
            s2_mant_d = res_mant;
            s2_zero_d = res_zero;
            s2_ovf_d  = res_ovf;
            s2_unf_d  = res_unf;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid_q <= 1'b0;
         s1_exp_q   <= '0;
         s1_mant_q  <= '0;
         s1_carry_q <= 1'b0;
         s1_lzc_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_exp_q   <= '0;
         s2_mant_q  <= '0;
         s2_zero_q  <= 1'b0;
         s2_ovf_q   <= 1'b0;
         s2_unf_q   <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_exp_q   <= s1_exp_d;
         s1_mant_q  <= s1_mant_d;
         s1_carry_q <= s1_carry_d;
         s1_lzc_q   <= s1_lzc_d;
         s2_valid_q <= s2_valid_d;
         s2_exp_q   <= s2_exp_d;
         s2_mant_q  <= s2_mant_d;
         s2_zero_q  <= s2_zero_d;
         s2_ovf_q   <= s2_ovf_d;
         s2_unf_q   <= s2_unf_d;
      end
   end

   assign bus.o_valid     = s2_valid_q;
   assign bus.o_exp       = s2_exp_q;
   assign bus.o_mant      = s2_mant_q;
   assign bus.o_zero      = s2_zero_q;
   assign bus.o_overflow  = s2_ovf_q;
   assign bus.o_underflow = s2_unf_q;

`ifdef EXP_NORM_INEXACT_EN
   logic res_inexact;
   logic s2_inexact_q, s2_inexact_d;

   // Set when a 1 is lost: the carry shift's LSB, or any fraction bits behind an overflow/underflow.
   always_comb begin
      res_inexact  = (s1_carry_q & s1_mant_q[0])
                   | (res_ovf & (|s1_mant_q[W-2:0]))
                   | res_unf;
      s2_inexact_d = s2_inexact_q;
      if (s2_load && s1_valid_q) s2_inexact_d = res_inexact;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) s2_inexact_q <= 1'b0;
      else          s2_inexact_q <= s2_inexact_d;
   end

   assign bus.o_inexact = s2_inexact_q;
`endif
endmodule
